// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the boot-time instruction ROM loader.
`timescale 1ns/1ps
package inst_rom_loader_pkg;

  localparam int INST_MEM_NUM_LOG2 = 10;
  localparam int INST_ADDR_W       = 32;
  localparam int INST_W            = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  typedef enum logic [1:0] {
    LD_LOAD = 2'd0,
    LD_RUN  = 2'd1,
    LD_ERR  = 2'd2
  } ld_state_e;

  // Big-endian lane placement: byte 0 of a word lands in the MSBs.
  function automatic inst_t place_byte(input inst_t word, input logic [7:0] b,
                                       input logic [1:0] k);
    inst_t r;
    r = word;
    case (k)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inst_rom_loader_if.sv
// Load byte stream and instruction-fetch bus between the loader and its neighbours.
`timescale 1ns/1ps
interface inst_rom_loader_if;
  import inst_rom_loader_pkg::*;

  logic       ld_valid_i;
  logic [7:0] ld_data_i;
  logic       ld_last_i;
  logic       ld_ready_o;
  logic       rom_ce_i;
  inst_addr_t rom_addr_i;
  inst_t      rom_data_o;

  modport slave (
    input  ld_valid_i, ld_data_i, ld_last_i, rom_ce_i, rom_addr_i,
    output ld_ready_o, rom_data_o
  );

  modport master (
    output ld_valid_i, ld_data_i, ld_last_i, rom_ce_i, rom_addr_i,
    input  ld_ready_o, rom_data_o
  );

endinterface

// File: rtl/inst_rom_loader_inst_ram.sv
// DEPTH x 32 instruction RAM: synchronous write, asynchronous read for zero-wait fetch.
`timescale 1ns/1ps
module inst_rom_loader_inst_ram
  import inst_rom_loader_pkg::*;
#(
  parameter int AW = INST_MEM_NUM_LOG2
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  inst_t         i_wdata,
  input  logic [AW-1:0] i_raddr,
  output inst_t         o_rdata
);

  inst_t r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Boot loader: packs a byte stream into instruction RAM, then releases the core
// and serves its fetches combinationally.
`timescale 1ns/1ps
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int DEPTH_LOG2 = INST_MEM_NUM_LOG2
) (
  input  logic             clk,
  input  logic             rst,
  inst_rom_loader_if.slave bus,
  output logic             cpu_rst_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  ld_state_e             r_state, w_state_next;
  logic [1:0]            r_byte_cnt, w_byte_cnt_next;
  logic [DEPTH_LOG2:0]   r_word_cnt, w_word_cnt_next;
  inst_t                 r_asm, w_asm_next;
  logic                  r_cpu_rst, r_done, r_err;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_we;
  inst_t                 w_packed;
  logic [DEPTH_LOG2-1:0] w_idx;
  inst_t                 w_rd_data;
  logic                  w_hit;
  logic                  w_addr_unused;

  assign w_ready        = (r_state == LD_LOAD);
  assign bus.ld_ready_o = w_ready;
  assign w_accept       = bus.ld_valid_i & w_ready;
  assign w_packed       = place_byte(r_asm, bus.ld_data_i, r_byte_cnt);

  always_comb begin
    w_state_next    = r_state;
    w_byte_cnt_next = r_byte_cnt;
    w_word_cnt_next = r_word_cnt;
    w_asm_next      = r_asm;
    w_we            = 1'b0;
    case (r_state)
      LD_LOAD: begin
        if (w_accept) begin
          if (r_word_cnt == FULL_CNT) begin
            // Overflowing byte is dropped; the image is unusable.
            w_state_next = LD_ERR;
          end else if (r_byte_cnt == 2'd3 || bus.ld_last_i) begin
            w_we            = 1'b1;
            w_word_cnt_next = r_word_cnt + 1'b1;
            w_byte_cnt_next = 2'd0;
            w_asm_next      = '0;
            if (bus.ld_last_i) begin
              w_state_next = LD_RUN;
            end
          end else begin
            w_asm_next      = w_packed;
            w_byte_cnt_next = r_byte_cnt + 2'd1;
          end
        end
      end
      LD_RUN:  w_state_next = LD_RUN;
      default: w_state_next = LD_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= LD_LOAD;
      r_byte_cnt <= 2'd0;
      r_word_cnt <= '0;
      r_asm      <= '0;
      r_cpu_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_byte_cnt <= w_byte_cnt_next;
      r_word_cnt <= w_word_cnt_next;
      r_asm      <= w_asm_next;
      r_cpu_rst  <= (w_state_next != LD_RUN);
      r_done     <= (w_state_next == LD_RUN);
      r_err      <= (w_state_next == LD_ERR);
    end
  end

  assign cpu_rst_o = r_cpu_rst;
  assign done_o    = r_done;
  assign err_o     = r_err;

  inst_rom_loader_inst_ram #(
    .AW (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_word_cnt[DEPTH_LOG2-1:0]),
    .i_wdata (w_packed),
    .i_raddr (w_idx),
    .o_rdata (w_rd_data)
  );

  // Fetches wrap modulo DEPTH; words beyond the loaded count read as zero
  // so stale RAM from an earlier aborted load never reaches the core.
  assign w_idx = bus.rom_addr_i[DEPTH_LOG2+1:2];
  assign w_hit = bus.rom_ce_i && (r_state == LD_RUN) && ({1'b0, w_idx} < r_word_cnt);
  assign bus.rom_data_o = w_hit ? w_rd_data : '0;

  assign w_addr_unused = ^{bus.rom_addr_i[INST_ADDR_W-1:DEPTH_LOG2+2], bus.rom_addr_i[1:0]};

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: a DEPTH_LOG2=10 instance and a tiny DEPTH_LOG2=2 one.
`timescale 1ns/1ps
module tb_inst_rom_loader;
  import inst_rom_loader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic cpu_rst_a, done_a, err_a;
  logic cpu_rst_b, done_b, err_b;

  inst_rom_loader_if if_a();
  inst_rom_loader_if if_b();

  inst_rom_loader #(.DEPTH_LOG2(10)) dut_a (
    .clk(clk), .rst(rst_a), .bus(if_a.slave),
    .cpu_rst_o(cpu_rst_a), .done_o(done_a), .err_o(err_a)
  );

  inst_rom_loader #(.DEPTH_LOG2(2)) dut_b (
    .clk(clk), .rst(rst_b), .bus(if_b.slave),
    .cpu_rst_o(cpu_rst_b), .done_o(done_b), .err_o(err_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%08h exp=%08h", name, act, exp);
    end else begin
      $display("ok   %s act=%08h", name, act);
    end
  endtask

  task automatic send_a(input logic [7:0] d, input logic last);
    @(negedge clk);
    if_a.ld_valid_i = 1'b1;
    if_a.ld_data_i  = d;
    if_a.ld_last_i  = last;
    @(posedge clk);
    #1;
    if_a.ld_valid_i = 1'b0;
    if_a.ld_last_i  = 1'b0;
    if_a.ld_data_i  = 8'h5A;
  endtask

  task automatic send_b(input logic [7:0] d, input logic last);
    @(negedge clk);
    if_b.ld_valid_i = 1'b1;
    if_b.ld_data_i  = d;
    if_b.ld_last_i  = last;
    @(posedge clk);
    #1;
    if_b.ld_valid_i = 1'b0;
    if_b.ld_last_i  = 1'b0;
  endtask

  // Idle cycles with junk on data/last but valid low.
  task automatic gap_a(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if_a.ld_valid_i = 1'b0;
      if_a.ld_data_i  = 8'($urandom);
      if_a.ld_last_i  = 1'($urandom);
      @(posedge clk);
      #1;
      if_a.ld_last_i  = 1'b0;
    end
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
  endtask

  task automatic run_table_a();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      if_a.rom_ce_i   = tbl[i].ce;
      if_a.rom_addr_i = tbl[i].addr;
      #1;
      chk(tbl[i].name, if_a.rom_data_o, tbl[i].exp);
    end
    tbl.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1 [8];
    logic [7:0] t3 [5];
    logic [7:0] t6 [4];

    t1 = '{8'h3C, 8'h01, 8'h12, 8'h34, 8'h34, 8'h21, 8'h56, 8'h78};
    t3 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    t6 = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.ld_valid_i = 1'b0; if_a.ld_data_i = 8'h00; if_a.ld_last_i = 1'b0;
    if_a.rom_ce_i   = 1'b0; if_a.rom_addr_i = '0;
    if_b.ld_valid_i = 1'b0; if_b.ld_data_i = 8'h00; if_b.ld_last_i = 1'b0;
    if_b.rom_ce_i   = 1'b0; if_b.rom_addr_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset state
    if_a.rom_ce_i = 1'b1;
    #1;
    chk("rst_cpu_rst", 32'(cpu_rst_a), 32'd1);
    chk("rst_done",    32'(done_a),    32'd0);
    chk("rst_err",     32'(err_a),     32'd0);
    chk("rst_ready",   32'(if_a.ld_ready_o), 32'd1);
    chk("rst_rom_data", if_a.rom_data_o, 32'h0);

    // Two-word image, core released after the last byte
    for (int i = 0; i < 8; i++) begin
      send_a(t1[i], i == 7);
      if (i == 6) chk("t1_cpu_rst_held", 32'(cpu_rst_a), 32'd1);
    end
    chk("t1_cpu_rst_fall", 32'(cpu_rst_a), 32'd0);
    chk("t1_done",         32'(done_a),    32'd1);
    chk("t1_ready_run",    32'(if_a.ld_ready_o), 32'd0);

    tbl.push_back('{"t1_addr0",      1'b1, 32'h0000_0000, 32'h3C01_1234});
    tbl.push_back('{"t1_addr4",      1'b1, 32'h0000_0004, 32'h3421_5678});
    tbl.push_back('{"t2_ce0_addr4",  1'b0, 32'h0000_0004, 32'h0000_0000});
    tbl.push_back('{"t2_addr8",      1'b1, 32'h0000_0008, 32'h0000_0000});
    tbl.push_back('{"t2_addr1",      1'b1, 32'h0000_0001, 32'h3C01_1234});
    tbl.push_back('{"t2_wrap_1000",  1'b1, 32'h0000_1000, 32'h3C01_1234});
    tbl.push_back('{"t2_wrap_1006",  1'b1, 32'hFFFF_F006, 32'h3421_5678});
    run_table_a();

    // Bytes offered in RUN must be ignored
    @(negedge clk);
    if_a.ld_valid_i = 1'b1;
    if_a.ld_data_i  = 8'hFF;
    if_a.ld_last_i  = 1'b1;
    #1;
    chk("run_ready_low", 32'(if_a.ld_ready_o), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    if_a.ld_valid_i = 1'b0;
    if_a.ld_last_i  = 1'b0;
    chk("run_done_kept", 32'(done_a), 32'd1);
    tbl.push_back('{"run_addr0", 1'b1, 32'h0, 32'h3C01_1234});
    tbl.push_back('{"run_addr4", 1'b1, 32'h4, 32'h3421_5678});
    tbl.push_back('{"run_addr8", 1'b1, 32'h8, 32'h0000_0000});
    run_table_a();

    // Partial final word with random valid gaps
    reset_a();
    chk("t3_cpu_rst_after_rst", 32'(cpu_rst_a), 32'd1);
    chk("t3_done_after_rst",    32'(done_a),    32'd0);
    for (int i = 0; i < 5; i++) begin
      gap_a(int'($urandom_range(0, 3)));
      send_a(t3[i], i == 4);
    end
    chk("t3_done", 32'(done_a), 32'd1);
    tbl.push_back('{"t3_word0", 1'b1, 32'h0, 32'hAABB_CCDD});
    tbl.push_back('{"t3_word1", 1'b1, 32'h4, 32'hEE00_0000});
    tbl.push_back('{"t3_word2", 1'b1, 32'h8, 32'h0000_0000});
    run_table_a();

    // Reset mid-load, then last on the 4th byte
    reset_a();
    for (int i = 0; i < 6; i++) send_a(8'(i + 1), 1'b0);
    reset_a();
    chk("t6_cpu_rst_after_pulse", 32'(cpu_rst_a), 32'd1);
    for (int i = 0; i < 4; i++) begin
      send_a(t6[i], i == 3);
      if (i == 2) chk("t6_cpu_rst_held", 32'(cpu_rst_a), 32'd1);
    end
    chk("t6_cpu_rst_fall", 32'(cpu_rst_a), 32'd0);
    tbl.push_back('{"t6_addr0", 1'b1, 32'h0, 32'h1122_3344});
    tbl.push_back('{"t6_addr4_masked", 1'b1, 32'h4, 32'h0000_0000});
    run_table_a();

    // Overflow on the 4-word instance
    for (int i = 0; i < 16; i++) send_b(8'(8'h10 + i), 1'b0);
    chk("ovf_err_before", 32'(err_b), 32'd0);
    chk("ovf_ready_before", 32'(if_b.ld_ready_o), 32'd1);
    send_b(8'h99, 1'b0);
    chk("ovf_err",     32'(err_b),     32'd1);
    chk("ovf_ready",   32'(if_b.ld_ready_o), 32'd0);
    chk("ovf_cpu_rst", 32'(cpu_rst_b), 32'd1);
    chk("ovf_done",    32'(done_b),    32'd0);
    @(negedge clk);
    if_b.rom_ce_i   = 1'b1;
    if_b.rom_addr_i = 32'h0;
    #1;
    chk("ovf_rom_data", if_b.rom_data_o, 32'h0);
    send_b(8'h77, 1'b1);
    chk("ovf_err_sticky", 32'(err_b), 32'd1);
    chk("ovf_done_sticky", 32'(done_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
